// File: rtl/vector_unit_scheduler_pkg.sv
// Shared types for the vector unit scheduler: unit selector and scheduler FSM state.
package vector_unit_scheduler_pkg;

  typedef enum logic [1:0] {
    VU_ADD   = 2'd0,
    VU_SHIFT = 2'd1,
    VU_COMP  = 2'd2,
    VU_MUL   = 2'd3
  } vunit_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } sched_state_t;

  localparam int unsigned CONFLICT_CNT_W = 16;

endpackage

// File: rtl/vsched_wb_pipe.sv
// Writeback reservation pipeline: slot 0 is the head that retires this cycle, every
// slot moves one step toward the head per clock, and new entries land after the shift.
module vsched_wb_pipe #(
  parameter int DEPTH     = 3,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic                 push_mul_i,
  input  logic [TAG_WIDTH-1:0] push_tag_i,
  input  logic [1:0]           push_unit_i,
  output logic                 head_valid_o,
  output logic [TAG_WIDTH-1:0] head_tag_o,
  output logic [1:0]           head_unit_o,
  output logic                 next_valid_o,
  output logic                 any_valid_o
);

  localparam int TAIL = DEPTH - 1;

  logic [DEPTH-1:0]                valid_q, valid_d;
  logic [DEPTH-1:0][TAG_WIDTH-1:0] tag_q, tag_d;
  logic [DEPTH-1:0][1:0]           unit_q, unit_d;

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    valid_d = '0;
    tag_d   = '0;
    unit_d  = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      valid_d[i] = valid_q[i+1];
      tag_d[i]   = tag_q[i+1];
      unit_d[i]  = unit_q[i+1];
    end
    if (push_i) begin
      if (push_mul_i) begin
        valid_d[TAIL] = 1'b1;
        tag_d[TAIL]   = push_tag_i;
        unit_d[TAIL]  = push_unit_i;
      end else begin
        valid_d[0] = 1'b1;
        tag_d[0]   = push_tag_i;
        unit_d[0]  = push_unit_i;
      end
    end
    if (flush_i) valid_d = '0;
  end

  // NOTE: the slot array is a handful of flops, so tags are reset along with the valids.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      tag_q   <= '0;
      unit_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      unit_q  <= unit_d;
    end
  end

  assign head_valid_o = valid_q[0];
  assign head_tag_o   = tag_q[0];
  assign head_unit_o  = unit_q[0];
  assign next_valid_o = valid_q[1];
  assign any_valid_o  = |valid_q;

endmodule

// File: rtl/vector_unit_scheduler.sv
// Issue scheduler for four vector units sharing one writeback port; single-cycle ops
// stall when a multiply is about to claim the port, drain/flush control the pipeline.
module vector_unit_scheduler
  import vector_unit_scheduler_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      issue_valid_i,
  input  logic [1:0]                issue_unit_i,
  input  logic [TAG_WIDTH-1:0]      issue_tag_i,
  output logic                      issue_ready_o,
  output logic                      add_en_o,
  output logic                      shift_en_o,
  output logic                      comp_en_o,
  output logic                      mul_en_o,
  output logic                      wb_valid_o,
  output logic [TAG_WIDTH-1:0]      wb_tag_o,
  output logic [1:0]                wb_unit_o,
  input  logic                      flush_i,
  input  logic                      drain_i,
  output logic                      drained_o,
  output logic                      idle_o,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt_o
);

  sched_state_t              state_q, state_d;
  vunit_t                    unit;
  logic                      conflict, accept;
  logic                      head_valid, next_valid, any_valid;
  logic [CONFLICT_CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  assign unit     = vunit_t'(issue_unit_i);
  // The entry in slot 1 reaches the head next cycle, exactly where a 1-cycle op would land.
  assign conflict = (unit != VU_MUL) && next_valid;

  // NOTE: state registers use non-blocking assignments; combinational blocks use blocking.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain_i)    state_d = ST_DRAIN;
      ST_DRAIN: if (!any_valid) state_d = ST_RUN;
      default:                  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    issue_ready_o = rst_n_i && (state_q == ST_RUN) && !drain_i && !flush_i && !conflict;
    accept        = issue_valid_i && issue_ready_o;
    add_en_o      = accept && (unit == VU_ADD);
    shift_en_o    = accept && (unit == VU_SHIFT);
    comp_en_o     = accept && (unit == VU_COMP);
    mul_en_o      = accept && (unit == VU_MUL);
    drained_o     = (state_q == ST_DRAIN) && !any_valid;
  end

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (issue_valid_i && conflict && !flush_i && (conflict_cnt_q != '1))
      conflict_cnt_d = conflict_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) conflict_cnt_q <= '0;
    else          conflict_cnt_q <= conflict_cnt_d;
  end

  vsched_wb_pipe #(
    .DEPTH     (MUL_LATENCY),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_wb_pipe (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .flush_i      (flush_i),
    .push_i       (accept),
    .push_mul_i   (unit == VU_MUL),
    .push_tag_i   (issue_tag_i),
    .push_unit_i  (issue_unit_i),
    .head_valid_o (head_valid),
    .head_tag_o   (wb_tag_o),
    .head_unit_o  (wb_unit_o),
    .next_valid_o (next_valid),
    .any_valid_o  (any_valid)
  );

  assign wb_valid_o     = head_valid && !flush_i;
  assign idle_o         = !any_valid;
  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_vector_unit_scheduler.sv
// Self-checking bench for vector_unit_scheduler: directed scenarios with literal
// expectations plus random traffic compared against a due-time writeback model.
module tb_vector_unit_scheduler;
  import vector_unit_scheduler_pkg::*;

  localparam int L  = 3;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          issue_valid_i = 1'b0;
  logic [1:0]    issue_unit_i = 2'd0;
  logic [TW-1:0] issue_tag_i = '0;
  logic          flush_i = 1'b0;
  logic          drain_i = 1'b0;
  logic          issue_ready_o, add_en_o, shift_en_o, comp_en_o, mul_en_o;
  logic          wb_valid_o, drained_o, idle_o;
  logic [TW-1:0] wb_tag_o;
  logic [1:0]    wb_unit_o;
  logic [15:0]   conflict_cnt_o;

  vector_unit_scheduler #(.MUL_LATENCY(L), .TAG_WIDTH(TW)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n_i),
    .issue_valid_i  (issue_valid_i),
    .issue_unit_i   (issue_unit_i),
    .issue_tag_i    (issue_tag_i),
    .issue_ready_o  (issue_ready_o),
    .add_en_o       (add_en_o),
    .shift_en_o     (shift_en_o),
    .comp_en_o      (comp_en_o),
    .mul_en_o       (mul_en_o),
    .wb_valid_o     (wb_valid_o),
    .wb_tag_o       (wb_tag_o),
    .wb_unit_o      (wb_unit_o),
    .flush_i        (flush_i),
    .drain_i        (drain_i),
    .drained_o      (drained_o),
    .idle_o         (idle_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each accepted op is a pending writeback with an absolute due cycle.
  typedef struct {
    int            due;
    logic [TW-1:0] tag;
    logic [1:0]    unit;
  } wb_t;

  wb_t         pend[$];
  int          cyc;
  bit          m_drain;
  logic [15:0] m_cnt;

  logic          obs_ready, obs_wb_valid, obs_drained, obs_idle;
  logic [3:0]    obs_en;
  logic [TW-1:0] obs_wb_tag;
  logic [1:0]    obs_wb_unit;
  logic [15:0]   obs_cnt;
  logic          exp_ready, exp_wb_valid, exp_drained, exp_idle;
  logic [3:0]    exp_en;
  logic [TW-1:0] exp_wb_tag;
  logic [1:0]    exp_wb_unit;
  logic [15:0]   exp_cnt;

  task automatic model_reset();
    pend.delete();
    cyc     = 0;
    m_drain = 0;
    m_cnt   = '0;
  endtask

  // One clock cycle: drive after the falling edge, sample 1 ns later, advance model at the rising edge.
  task automatic step(input bit v, input logic [1:0] u, input logic [TW-1:0] t,
                      input bit fl, input bit dr);
    bit conflict, empty, acc;
    int hit;
    issue_valid_i = v;
    issue_unit_i  = u;
    issue_tag_i   = t;
    flush_i       = fl;
    drain_i       = dr;
    #1;
    obs_ready    = issue_ready_o;
    obs_en       = {mul_en_o, comp_en_o, shift_en_o, add_en_o};
    obs_wb_valid = wb_valid_o;
    obs_wb_tag   = wb_tag_o;
    obs_wb_unit  = wb_unit_o;
    obs_drained  = drained_o;
    obs_idle     = idle_o;
    obs_cnt      = conflict_cnt_o;
    hit      = -1;
    conflict = 0;
    foreach (pend[i]) begin
      if (pend[i].due == cyc) hit = i;
      if (pend[i].due == cyc + 1 && u != VU_MUL) conflict = 1;
    end
    empty        = (pend.size() == 0);
    exp_wb_valid = (hit >= 0) && !fl;
    exp_wb_tag   = (hit >= 0) ? pend[hit].tag : '0;
    exp_wb_unit  = (hit >= 0) ? pend[hit].unit : '0;
    exp_ready    = !m_drain && !dr && !fl && !conflict;
    acc          = v && exp_ready;
    exp_en       = acc ? (4'b0001 << u) : 4'b0000;
    exp_idle     = empty;
    exp_drained  = m_drain && empty;
    exp_cnt      = m_cnt;
    @(posedge clk);
    if (v && conflict && !fl && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (hit >= 0) pend.delete(hit);
    if (fl) pend.delete();
    if (acc) pend.push_back('{cyc + ((u == VU_MUL) ? L : 1), t, u});
    if (!m_drain) m_drain = dr;
    else if (empty) m_drain = 0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n_i       = 1'b0;
    issue_valid_i = 1'b1;
    issue_unit_i  = VU_ADD;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", issue_ready_o); end
    checks++; if ({mul_en_o, comp_en_o, shift_en_o, add_en_o} !== 4'b0) begin errors++; $display("FAIL reset_en: got %b%b%b%b expected 0000", mul_en_o, comp_en_o, shift_en_o, add_en_o); end
    checks++; if (wb_valid_o !== 1'b0 || drained_o !== 1'b0) begin errors++; $display("FAIL reset_wb_drained: got %b/%b expected 0/0", wb_valid_o, drained_o); end
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle_o); end
    checks++; if (conflict_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0h expected 0", conflict_cnt_o); end
    @(negedge clk);
    rst_n_i       = 1'b1;
    issue_valid_i = 1'b0;
    model_reset();
  endtask

  task automatic test_mul_latency();
    step(1, VU_MUL, 4'd1, 0, 0);
    checks++; if (obs_en !== 4'b1000) begin errors++; $display("FAIL mul_en: got %b expected 1000", obs_en); end
    for (int k = 1; k <= 3; k++) begin
      step(0, VU_ADD, 4'd0, 0, 0);
      checks++;
      if (obs_wb_valid !== (k == 3)) begin errors++; $display("FAIL mul_wb_valid c%0d: got %b expected %b", k, obs_wb_valid, (k == 3)); end
    end
    checks++; if (obs_wb_tag !== 4'd1 || obs_wb_unit !== VU_MUL) begin errors++; $display("FAIL mul_wb_tag: got %0h/%0d expected 1/3", obs_wb_tag, obs_wb_unit); end
    step(0, VU_ADD, 4'd0, 0, 0);
    checks++; if (obs_idle !== 1'b1) begin errors++; $display("FAIL mul_idle_after: got %b expected 1", obs_idle); end
  endtask

  task automatic test_conflict();
    step(1, VU_MUL, 4'd2, 0, 0);
    step(0, VU_ADD, 4'd0, 0, 0);
    step(1, VU_ADD, 4'd3, 0, 0);
    checks++; if (obs_ready !== 1'b0 || obs_en !== 4'b0) begin errors++; $display("FAIL conflict_stall: got ready %b en %b expected 0/0000", obs_ready, obs_en); end
    step(1, VU_ADD, 4'd3, 0, 0);
    checks++; if (obs_ready !== 1'b1 || obs_en !== 4'b0001) begin errors++; $display("FAIL conflict_accept: got ready %b en %b expected 1/0001", obs_ready, obs_en); end
    checks++; if (obs_wb_valid !== 1'b1 || obs_wb_tag !== 4'd2) begin errors++; $display("FAIL conflict_wb_mul: got %b/%0h expected 1/2", obs_wb_valid, obs_wb_tag); end
    step(0, VU_ADD, 4'd0, 0, 0);
    checks++; if (obs_wb_valid !== 1'b1 || obs_wb_tag !== 4'd3) begin errors++; $display("FAIL conflict_wb_add: got %b/%0h expected 1/3", obs_wb_valid, obs_wb_tag); end
    checks++; if (obs_cnt !== 16'd1) begin errors++; $display("FAIL conflict_cnt: got %0d expected 1", obs_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops[4] = '{VU_ADD, VU_SHIFT, VU_COMP, VU_MUL};
    int         wbt[8] = '{-1, 4, 5, 6, -1, -1, 7, -1};
    int         wbu[8] = '{0, 0, 1, 2, 0, 0, 3, 0};
    for (int k = 0; k < 8; k++) begin
      if (k < 4) step(1, ops[k], TW'(k + 4), 0, 0);
      else       step(0, VU_ADD, 4'd0, 0, 0);
      if (k < 4) begin
        checks++;
        if (obs_ready !== 1'b1 || obs_en !== (4'b0001 << ops[k])) begin errors++; $display("FAIL b2b_issue c%0d: got ready %b en %b", k, obs_ready, obs_en); end
      end
      checks++;
      if (obs_wb_valid !== (wbt[k] >= 0)) begin errors++; $display("FAIL b2b_wb_valid c%0d: got %b expected %b", k, obs_wb_valid, (wbt[k] >= 0)); end
      else if (wbt[k] >= 0 && (obs_wb_tag !== TW'(wbt[k]) || obs_wb_unit !== 2'(wbu[k]))) begin
        errors++; $display("FAIL b2b_wb_tag c%0d: got %0h/%0d expected %0h/%0d", k, obs_wb_tag, obs_wb_unit, wbt[k], wbu[k]);
      end
    end
  endtask

  task automatic test_flush();
    step(1, VU_MUL, 4'd8, 0, 0);
    step(1, VU_MUL, 4'd9, 0, 0);
    step(1, VU_ADD, 4'd10, 1, 0);
    checks++; if (obs_ready !== 1'b0 || obs_en !== 4'b0 || obs_wb_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle: got ready %b en %b wb %b expected 0", obs_ready, obs_en, obs_wb_valid); end
    for (int k = 2; k < 6; k++) begin
      step(0, VU_ADD, 4'd0, 0, 0);
      checks++;
      if (obs_wb_valid !== 1'b0 || obs_idle !== 1'b1) begin errors++; $display("FAIL flush_after c%0d: got wb %b idle %b expected 0/1", k, obs_wb_valid, obs_idle); end
    end
    checks++; if (obs_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt_hold: got %0d expected 1", obs_cnt); end
    step(1, VU_MUL, 4'd11, 0, 0);
    step(0, VU_ADD, 4'd0, 1, 1);
    step(0, VU_ADD, 4'd0, 0, 0);
    checks++; if (obs_drained !== 1'b1 || obs_ready !== 1'b0 || obs_idle !== 1'b1) begin errors++; $display("FAIL flush_drain: got drained %b ready %b idle %b expected 1/0/1", obs_drained, obs_ready, obs_idle); end
    step(0, VU_ADD, 4'd0, 0, 0);
    checks++; if (obs_ready !== 1'b1 || obs_drained !== 1'b0) begin errors++; $display("FAIL flush_drain_resume: got ready %b drained %b expected 1/0", obs_ready, obs_drained); end
  endtask

  task automatic test_drain();
    int pulses = 0;
    step(1, VU_MUL, 4'd9, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      step(1, VU_ADD, 4'd12, (k == 1) ? 1'b0 : 1'b0, k == 1);
      if (obs_drained) pulses++;
      if (k <= 4) begin
        checks++;
        if (obs_ready !== 1'b0 || obs_en !== 4'b0) begin errors++; $display("FAIL drain_ready c%0d: got %b expected 0", k, obs_ready); end
      end
      if (k == 3) begin
        checks++; if (obs_wb_valid !== 1'b1 || obs_wb_tag !== 4'd9) begin errors++; $display("FAIL drain_wb: got %b/%0h expected 1/9", obs_wb_valid, obs_wb_tag); end
      end
      if (k == 4) begin
        checks++; if (obs_drained !== 1'b1) begin errors++; $display("FAIL drain_pulse: got %b expected 1", obs_drained); end
      end
      if (k == 5) begin
        checks++; if (obs_en !== 4'b0001) begin errors++; $display("FAIL drain_resume: got en %b expected 0001", obs_en); end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL drain_pulse_count: got %0d expected 1", pulses); end
    step(0, VU_ADD, 4'd0, 0, 1);
    step(0, VU_ADD, 4'd0, 0, 0);
    checks++; if (obs_drained !== 1'b1) begin errors++; $display("FAIL drain_idle_pulse: got %b expected 1", obs_drained); end
    step(0, VU_ADD, 4'd0, 0, 0);
    checks++; if (obs_ready !== 1'b1 || obs_drained !== 1'b0) begin errors++; $display("FAIL drain_idle_resume: got ready %b drained %b expected 1/0", obs_ready, obs_drained); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), TW'($urandom),
           $urandom_range(0, 24) == 0, $urandom_range(0, 29) == 0);
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", cyc, obs_ready, exp_ready); end
      checks++; if (obs_en !== exp_en) begin errors++; $display("FAIL rnd_en c%0d: got %b expected %b", cyc, obs_en, exp_en); end
      checks++; if (obs_wb_valid !== exp_wb_valid) begin errors++; $display("FAIL rnd_wb_valid c%0d: got %b expected %b", cyc, obs_wb_valid, exp_wb_valid); end
      if (exp_wb_valid) begin
        checks++;
        if (obs_wb_tag !== exp_wb_tag || obs_wb_unit !== exp_wb_unit) begin errors++; $display("FAIL rnd_wb_tag c%0d: got %0h/%0d expected %0h/%0d", cyc, obs_wb_tag, obs_wb_unit, exp_wb_tag, exp_wb_unit); end
      end
      checks++; if (obs_idle !== exp_idle) begin errors++; $display("FAIL rnd_idle c%0d: got %b expected %b", cyc, obs_idle, exp_idle); end
      checks++; if (obs_drained !== exp_drained) begin errors++; $display("FAIL rnd_drained c%0d: got %b expected %b", cyc, obs_drained, exp_drained); end
      checks++; if (obs_cnt !== exp_cnt) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d expected %0d", cyc, obs_cnt, exp_cnt); end
    end
  endtask

  task automatic test_mid_reset();
    step(1, VU_MUL, 4'd5, 0, 0);
    step(0, VU_ADD, 4'd0, 0, 0);
    rst_n_i       = 1'b0;
    issue_valid_i = 1'b1;
    issue_unit_i  = VU_ADD;
    #1;
    checks++; if (issue_ready_o !== 1'b0 || {mul_en_o, comp_en_o, shift_en_o, add_en_o} !== 4'b0) begin errors++; $display("FAIL midrst_ready_en: got %b expected 0", issue_ready_o); end
    checks++; if (wb_valid_o !== 1'b0 || drained_o !== 1'b0 || idle_o !== 1'b1) begin errors++; $display("FAIL midrst_outputs: got wb %b drained %b idle %b expected 0/0/1", wb_valid_o, drained_o, idle_o); end
    checks++; if (conflict_cnt_o !== 16'd0) begin errors++; $display("FAIL midrst_cnt: got %0h expected 0", conflict_cnt_o); end
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      step(0, VU_ADD, 4'd0, 0, 0);
      checks++;
      if (obs_wb_valid !== 1'b0 || obs_idle !== 1'b1) begin errors++; $display("FAIL midrst_no_wb c%0d: got wb %b idle %b expected 0/1", k, obs_wb_valid, obs_idle); end
    end
  endtask

  // MUL, MUL, ADD, ADD: each ADD meets a MUL in slot 1, giving two stalls per group.
  task automatic stall_groups(input int n);
    for (int g = 0; g < n; g++) begin
      step(1, VU_MUL, 4'd1, 0, 0);
      step(1, VU_MUL, 4'd2, 0, 0);
      step(1, VU_ADD, 4'd3, 0, 0);
      step(1, VU_ADD, 4'd3, 0, 0);
      checks++;
      if (obs_cnt !== exp_cnt) begin errors++; $display("FAIL sat_track g%0d: got %0h expected %0h", g, obs_cnt, exp_cnt); end
    end
    step(0, VU_ADD, 4'd0, 0, 0);
  endtask

  task automatic test_saturation();
    stall_groups(4);
    checks++; if (obs_cnt !== 16'd8) begin errors++; $display("FAIL sat_small: got %0d expected 8", obs_cnt); end
    force dut.conflict_cnt_q = 16'hFFF0;
    #1;
    release dut.conflict_cnt_q;
    m_cnt = 16'hFFF0;
    stall_groups(20);
    checks++; if (obs_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %0h expected ffff", obs_cnt); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mul_latency();
    test_conflict();
    test_back_to_back();
    test_flush();
    test_drain();
    test_random();
    test_mid_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
